nn_sample_feeder: RTL and testbench
===================================

// Module: nn_sample_feeder
// PURPOSE
//  Upstream driver for a single 7x9 MatMul layer stage configured as output layer; runs supervised training.
//  Holds a sample store of (input vector, target vector) pairs and runs NUM_EPOCHS passes over them.
//  Per sample: present input, strobe mult, collect forward result, present target, strobe backprop, collect delta.
//  Accumulates a saturating |output-target| error sum per epoch for host readout.
// PARAMETERS
//  ADDR_W   4    sample-store address width; DEPTH = 2**ADDR_W samples
//  PK_W     7    signed element width
//  PK_LEN   9    elements per packed vector (bus = PK_W*PK_LEN = 63 bits, element k at [7k+6:7k])
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high
//  wr_en        in   1       host write into sample store (ignored while busy)
//  wr_addr      in   ADDR_W  sample index written
//  wr_vec       in   63      packed input vector
//  wr_tgt       in   63      packed target vector
//  start        in   1       one-cycle pulse; begins training when idle
//  num_samples  in   ADDR_W+1 samples per epoch (1..DEPTH), latched at start
//  num_epochs   in   8       epochs to run (1..255), latched at start
//  busy         out  1       high from start accept until done
//  done         out  1       one-cycle pulse after last sample of last epoch
//  packed_out   out  63      vector driven to layer (input during forward, target during backprop)
//  mult         out  1       one-cycle forward strobe to layer
//  backprop     out  1       one-cycle backprop strobe to layer
//  output_layer out  1       tied 1 (layer computes delta against target)
//  layer_data   in   63      layer packed output
//  layer_valid  in   1       layer result valid
//  layer_ack    out  1       one-cycle acknowledge to layer
//  err_sum      out  16      unsigned saturating error sum of the last completed epoch
//  epoch_idx    out  8       current epoch; sample_idx out ADDR_W current sample
// BEHAVIOUR
//  Reset: all outputs 0 (packed_out=0, err_sum=0, busy=0), FSM->IDLE, acc=0; store contents undefined.
//  Store: synchronous write of {vec,tgt} on wr_en&!busy; read registered, 1-cycle latency.
//  FSM: IDLE -start&!busy-> RD (latch counts, idx=0, epoch=0, acc=0, busy=1)
//   RD: issue read(idx) -> LOAD: packed_out<=vec, tgt_r<=tgt -> FSTB: mult=1 for exactly 1 cycle
//   -> FWAIT: wait layer_valid; on valid: capture layer_data, layer_ack=1 one cycle -> FACK
//   FACK: layer_ack=0; packed_out<=tgt_r; acc+=sum_k |layer_k - tgt_k| -> BSETUP (target stable >=1 cycle)
//   BSETUP -> BSTB: backprop=1 one cycle, packed_out held -> BWAIT: wait layer_valid, ack one cycle -> NEXT
//   NEXT: idx==num_samples-1 ? (err_sum<=acc, acc=0, idx=0, epoch==num_epochs-1 ? DONE : epoch++,RD)
//         : idx++, RD.   DONE: done=1 one cycle, busy=0, packed_out=0 -> IDLE.
//  layer_ack never asserted without layer_valid seen high the prior cycle; never held >1 cycle.
//  FWAIT/BWAIT must not time out (layer valid arrives 2 cycles after strobe minimum).
//  Error arithmetic: diff computed 8-bit signed, |diff| <=128, summed 16-bit; acc saturates at 16'hFFFF.
//  start while busy ignored; wr_en while busy ignored; num_samples=0 or num_epochs=0 -> treated as 1.
//  Reset mid-run: immediate return to IDLE, strobes/ack drop same edge; layer must also be reset.
// TESTING
//  1 sample, vec=all 1, tgt=all 0, epochs=1; model layer returns all 3 -> mult/backprop pulses 1 cycle, err_sum=27, done once.
//  num_samples=3, epochs=2 -> exactly 6 mult and 6 backprop pulses, epoch_idx 0->1, busy high throughout.
//  Layer delays layer_valid 10 cycles -> FSM holds, ack single cycle after valid, packed_out stable.
//  Layer returns -64 vs tgt 63 on all 9, 60 samples -> err_sum saturates 16'hFFFF? (ADDR_W=6 run) no wrap.
//  start pulsed mid-run and wr_en mid-run -> no effect on counters or store contents.
//  reset asserted in BWAIT -> next cycle busy=0, mult=backprop=layer_ack=0, err_sum=0.

Source files
------------

// File: rtl/nn_sample_feeder.sv
// nn_sample_feeder: sample store plus training sequencer driving one
// MatMul output-layer stage (forward, error accumulate, backprop).
module nn_sample_feeder #(
  parameter int ADDR_W = 4,
  parameter int PK_W = 7,
  parameter int PK_LEN = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [PK_W*PK_LEN-1:0]   wr_vec,
  input  logic [PK_W*PK_LEN-1:0]   wr_tgt,
  input  logic                     start,
  input  logic [ADDR_W:0]          num_samples,
  input  logic [7:0]               num_epochs,
  output logic                     busy,
  output logic                     done,
  output logic [PK_W*PK_LEN-1:0]   packed_out,
  output logic                     mult,
  output logic                     backprop,
  output logic                     output_layer,
  input  logic [PK_W*PK_LEN-1:0]   layer_data,
  input  logic                     layer_valid,
  output logic                     layer_ack,
  output logic [15:0]              err_sum,
  output logic [7:0]               epoch_idx,
  output logic [ADDR_W-1:0]        sample_idx
);
  localparam int BW = PK_W * PK_LEN;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NS_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] NS_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_LOAD, S_FSTB, S_FWAIT, S_FACK,
    S_BSETUP, S_BSTB, S_BWAIT, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [2*BW-1:0] mem [DEPTH];
  logic [2*BW-1:0] rd_q;
  logic [BW-1:0]   tgt_r;
  logic [BW-1:0]   data_r;
  logic [ADDR_W:0] ns_r;
  logic [ADDR_W:0] ns_in;
  logic [7:0]      ne_r;
  logic [7:0]      ne_in;
  logic [15:0]     acc;
  logic [15:0]     err_now;
  logic [16:0]     acc_sum;
  logic            last_s;
  logic            last_e;

  // zero counts run once; oversize sample counts clamp to the store
  always_comb begin
    ns_in = num_samples;
    if (num_samples == '0) ns_in = NS_ONE;
    else if (num_samples > NS_MAX) ns_in = NS_MAX;
    ne_in = (num_epochs == 8'd0) ? 8'd1 : num_epochs;
  end

  assign last_s = ({1'b0, sample_idx} == ns_r - NS_ONE);
  assign last_e = (epoch_idx == ne_r - 8'd1);

  always_comb begin : err_calc
    logic [PK_W:0] a, b, d, m;
    err_now = '0;
    a = '0;
    b = '0;
    d = '0;
    m = '0;
    for (int k = 0; k < PK_LEN; k++) begin
      a = {data_r[k*PK_W+PK_W-1], data_r[k*PK_W +: PK_W]};
      b = {tgt_r[k*PK_W+PK_W-1], tgt_r[k*PK_W +: PK_W]};
      d = a - b;
      m = d[PK_W] ? -d : d;
      err_now = err_now + 16'(m);
    end
  end

  assign acc_sum = {1'b0, acc} + {1'b0, err_now};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_RD;
      S_RD:     state_nx = S_LOAD;
      S_LOAD:   state_nx = S_FSTB;
      S_FSTB:   state_nx = S_FWAIT;
      S_FWAIT:  if (layer_valid) state_nx = S_FACK;
      S_FACK:   state_nx = S_BSETUP;
      S_BSETUP: state_nx = S_BSTB;
      S_BSTB:   state_nx = S_BWAIT;
      S_BWAIT:  if (layer_valid) state_nx = S_NEXT;
      S_NEXT:   state_nx = (last_s && last_e) ? S_DONE : S_RD;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // ack lands in the cycle after valid was sampled (FACK / NEXT)
  always_comb begin
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
    mult = (state == S_FSTB);
    backprop = (state == S_BSTB);
    layer_ack = (state == S_FACK) || (state == S_NEXT);
  end

  assign output_layer = 1'b1;

  always_ff @(posedge clk) begin
    if (wr_en && !busy) mem[wr_addr] <= {wr_vec, wr_tgt};
    if (state == S_RD) rd_q <= mem[sample_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      packed_out <= '0;
      tgt_r <= '0;
      data_r <= '0;
      acc <= '0;
      err_sum <= '0;
      epoch_idx <= '0;
      sample_idx <= '0;
      ns_r <= NS_ONE;
      ne_r <= 8'd1;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ns_r <= ns_in;
          ne_r <= ne_in;
          sample_idx <= '0;
          epoch_idx <= '0;
          acc <= '0;
        end
        S_LOAD: begin
          packed_out <= rd_q[2*BW-1:BW];
          tgt_r <= rd_q[BW-1:0];
        end
        S_FWAIT: if (layer_valid) data_r <= layer_data;
        S_FACK: begin
          packed_out <= tgt_r;
          acc <= acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
        end
        S_NEXT: begin
          if (last_s) begin
            err_sum <= acc;
            acc <= '0;
            sample_idx <= '0;
            if (last_e) packed_out <= '0;
            else epoch_idx <= epoch_idx + 8'd1;
          end else begin
            sample_idx <= sample_idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nn_sample_feeder.sv
// tb_nn_sample_feeder: random training runs against a transaction-level
// model of the sample feeder, with a responding layer model.
module tb_nn_sample_feeder;
  localparam int AW = 6;
  localparam int PW = 7;
  localparam int PL = 9;
  localparam int BW = PW * PL;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset, wr_en, start;
  logic busy, done, mult, backprop, output_layer;
  logic layer_valid, layer_ack;
  logic [AW-1:0] wr_addr, sample_idx;
  logic [BW-1:0] wr_vec, wr_tgt, packed_out, layer_data;
  logic [AW:0] num_samples;
  logic [7:0] num_epochs, epoch_idx;
  logic [15:0] err_sum;

  always #5 clk = ~clk;

  nn_sample_feeder #(.ADDR_W(AW), .PK_W(PW), .PK_LEN(PL)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_vec(wr_vec), .wr_tgt(wr_tgt),
    .start(start), .num_samples(num_samples),
    .num_epochs(num_epochs),
    .busy(busy), .done(done),
    .packed_out(packed_out),
    .mult(mult), .backprop(backprop),
    .output_layer(output_layer),
    .layer_data(layer_data),
    .layer_valid(layer_valid),
    .layer_ack(layer_ack),
    .err_sum(err_sum),
    .epoch_idx(epoch_idx),
    .sample_idx(sample_idx)
  );

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 0;
  int resp_mode = 0;
  int dly = 0;

  logic [BW-1:0] m_vec [DEPTH];
  logic [BW-1:0] m_tgt [DEPTH];
  bit exp_busy, exp_done, pend;
  bit pm, pb, pa;
  int phase, cur_s, cur_e, ns_m, ne_m, acc_m;
  logic [15:0] exp_err;
  int n_mult, n_bp, n_done;

  function automatic logic [BW-1:0] rep(input logic [PW-1:0] v);
    return {PL{v}};
  endfunction

  function automatic int sample_err(input logic [BW-1:0] got,
                                    input logic [BW-1:0] tgt);
    int s = 0;
    for (int k = 0; k < PL; k++) begin
      int a = $signed(got[k*PW +: PW]);
      int b = $signed(tgt[k*PW +: PW]);
      s += (a > b) ? a - b : b - a;
    end
    return s;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_cycle();
    bit pd;
    if (chk_on) begin
      if (reset) begin
        exp_busy = 0; exp_done = 0; pend = 0;
        exp_err = '0; acc_m = 0; phase = 0;
        pm = 0; pb = 0; pa = 0;
        cmp("rst_mult", mult, 0);
        cmp("rst_bp", backprop, 0);
        cmp("rst_ack", layer_ack, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_err", err_sum, 0);
        cmp("rst_po", packed_out, 0);
      end else begin
        if (wr_en && !exp_busy) begin
          m_vec[wr_addr] = wr_vec;
          m_tgt[wr_addr] = wr_tgt;
        end
        pd = exp_done;
        exp_done = 0;
        if (start && !exp_busy && !pd) begin
          ns_m = (num_samples == 0) ? 1 :
                 (num_samples > DEPTH) ? DEPTH : int'(num_samples);
          ne_m = (num_epochs == 0) ? 1 : int'(num_epochs);
          cur_s = 0; cur_e = 0; acc_m = 0; phase = 0;
          exp_busy = 1;
        end
        if (pend) begin
          pend = 0;
          exp_err = 16'(acc_m);
          acc_m = 0;
          cur_s = 0;
          if (cur_e == ne_m - 1) begin
            exp_done = 1;
            exp_busy = 0;
          end else begin
            cur_e++;
          end
        end
        cmp("busy", busy, exp_busy);
        cmp("done", done, exp_done);
        cmp("err_sum", err_sum, exp_err);
        cmp("out_layer", output_layer, 1);
        if (done) n_done++;
        if (exp_done) cmp("po_done", packed_out, 0);
        if (mult) begin
          n_mult++;
          cmp("mult_busy", exp_busy, 1);
          cmp("mult_phase", phase, 0);
          cmp("mult_width", pm, 0);
          cmp("mult_sidx", sample_idx, cur_s);
          cmp("mult_eidx", epoch_idx, cur_e);
          phase = 1;
        end
        if (phase == 1) cmp("fwd_po", packed_out, m_vec[cur_s]);
        if (backprop) begin
          n_bp++;
          cmp("bp_phase", phase, 2);
          cmp("bp_width", pb, 0);
          phase = 3;
        end
        if (phase >= 2) cmp("bp_po", packed_out, m_tgt[cur_s]);
        if (layer_ack) begin
          cmp("ack_valid", layer_valid, 1);
          cmp("ack_width", pa, 0);
          if (phase == 1) begin
            acc_m += sample_err(layer_data, m_tgt[cur_s]);
            if (acc_m > 65535) acc_m = 65535;
            phase = 2;
          end else if (phase == 3) begin
            phase = 0;
            if (cur_s == ns_m - 1) pend = 1;
            else cur_s++;
          end else begin
            cmp("ack_phase", phase, 1);
          end
        end
        pm = mult; pb = backprop; pa = layer_ack;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [BW-1:0] v,
                    input logic [BW-1:0] t);
    wr_en = 1; wr_addr = AW'(a); wr_vec = v; wr_tgt = t;
    tick();
    wr_en = 0;
  endtask

  task automatic run(input int ns, input int ne, input bit poke);
    n_mult = 0; n_bp = 0; n_done = 0;
    num_samples = (AW+1)'(ns);
    num_epochs = 8'(ne);
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 8000 && n_done == 0; c++) begin
      if (poke && c == 20) begin
        start = 1; num_samples = 1; num_epochs = 1;
        wr_en = 1; wr_addr = 1;
        wr_vec = BW'({$urandom, $urandom});
        wr_tgt = BW'({$urandom, $urandom});
      end else if (poke && c == 21) begin
        start = 0; wr_en = 0;
      end
      tick();
    end
    cmp("run_done", n_done, 1);
    tick();
    tick();
  endtask

  // layer model: valid >= 2 cycles after a strobe, held until acked
  initial begin
    int d;
    layer_valid = 0;
    layer_data = '0;
    forever begin
      @(negedge clk);
      if (!reset && (mult || backprop)) begin
        d = (dly != 0) ? dly : int'($urandom_range(2, 5));
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          if (reset) break;
        end
        if (!reset) begin
          case (resp_mode)
            1: layer_data = rep(7'd3);
            2: layer_data = rep(7'h40);
            default: layer_data = BW'({$urandom, $urandom});
          endcase
          layer_valid = 1;
          for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (reset || layer_ack) break;
          end
        end
        layer_valid = 0;
      end
    end
  end

  initial begin
    int ns, ne;
    reset = 1; wr_en = 0; start = 0;
    wr_addr = '0; wr_vec = '0; wr_tgt = '0;
    num_samples = '0; num_epochs = '0;
    exp_busy = 0; exp_done = 0; pend = 0;
    pm = 0; pb = 0; pa = 0;
    phase = 0; cur_s = 0; cur_e = 0;
    ns_m = 1; ne_m = 1; acc_m = 0; exp_err = '0;
    n_mult = 0; n_bp = 0; n_done = 0;
    @(negedge clk);
    repeat (3) tick();
    chk_on = 1;
    tick();
    reset = 0;
    tick();
    cmp("init_busy", busy, 0);
    cmp("init_err", err_sum, 0);
    cmp("init_po", packed_out, 0);

    wr(0, rep(7'd1), '0);
    resp_mode = 1; dly = 2;
    run(1, 1, 0);
    cmp("t1_err", err_sum, 27);
    cmp("t1_mult", n_mult, 1);
    cmp("t1_bp", n_bp, 1);

    for (int i = 0; i < 16; i++)
      wr(i, BW'({$urandom, $urandom}), BW'({$urandom, $urandom}));
    resp_mode = 0; dly = 0;
    run(3, 2, 1);
    cmp("t2_mult", n_mult, 6);
    cmp("t2_bp", n_bp, 6);

    dly = 10;
    run(2, 1, 0);
    cmp("t3_mult", n_mult, 2);
    dly = 0;

    run(0, 0, 0);
    cmp("t4_mult", n_mult, 1);
    cmp("t4_bp", n_bp, 1);

    for (int r = 0; r < 4; r++) begin
      ns = int'($urandom_range(1, 16));
      ne = int'($urandom_range(1, 3));
      run(ns, ne, 0);
      cmp("rand_mult", n_mult, ns * ne);
    end

    for (int i = 0; i < 60; i++)
      wr(i, BW'({$urandom, $urandom}), rep(7'h3F));
    resp_mode = 2;
    run(60, 1, 0);
    cmp("sat_err", err_sum, 16'hFFFF);
    cmp("sat_mult", n_mult, 60);

    resp_mode = 0; dly = 5;
    n_bp = 0;
    num_samples = 2; num_epochs = 1;
    start = 1;
    tick();
    start = 0;
    for (int c = 0; c < 200 && n_bp == 0; c++) tick();
    cmp("bp_seen", n_bp, 1);
    tick();
    reset = 1;
    tick();
    tick();
    reset = 0;
    tick();
    cmp("post_busy", busy, 0);
    cmp("post_err", err_sum, 0);
    cmp("post_mult", mult, 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
